// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned AW_DEFAULT = 5;

  // Forward-select encodings for the E-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_p_if.sv
// Pipeline-register control fields into the hazard controller, and the controls it returns.
interface hazard_ctrl_p_if #(
  parameter int unsigned AW    = hazard_pkg::AW_DEFAULT,
  parameter int unsigned CNT_W = 16
);

  logic [AW-1:0]    RsD, RtD, RsE, RtE;
  logic [AW-1:0]    WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, RegWriteM, RegWriteW;
  logic             MemtoRegE, MemtoRegM;
  logic             BranchD, JumpD, PCSrcE;
  logic             MdStartE, MdUseD;
  logic             StallF, StallD, FlushE, FlushD;
  logic             ForwardAD, ForwardBD;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             MdBusy;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, JumpD, PCSrcE, MdStartE, MdUseD,
    input  StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD,
    input  ForwardAE, ForwardBE, MdBusy, StallCount, FlushCount
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, JumpD, PCSrcE, MdStartE, MdUseD,
    output StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD,
    output ForwardAE, ForwardBE, MdBusy, StallCount, FlushCount
  );

endinterface

// File: rtl/md_busy_counter.sv
// Mul/div busy tracker: loads MD_LAT on start and counts down; busy while non-zero.
module md_busy_counter #(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A start while already busy simply restarts the full latency
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(MD_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl_p.sv
// 5-stage MIPS hazard controller: forwarding selects, stall/flush controls,
// mul/div busy interlock and saturating stall/flush counters.
module hazard_ctrl_p
  import hazard_pkg::*;
#(
  parameter int unsigned AW           = AW_DEFAULT,
  parameter int unsigned MD_LAT       = 4,
  parameter bit          EARLY_BRANCH = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input logic           clk,
  input logic           reset,
  hazard_ctrl_p_if.slave hz
);

  logic             md_busy;
  logic             lwstall, branchstall, mdstall, stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  function automatic logic [1:0] fwd_e(input logic [AW-1:0] rx, input logic [AW-1:0] wm,
                                       input logic rwm, input logic [AW-1:0] ww,
                                       input logic rww);
    if (rx != '0 && rx == wm && rwm) return FWD_M;
    if (rx != '0 && rx == ww && rww) return FWD_W;
    return FWD_RF;
  endfunction

  md_busy_counter #(
    .MD_LAT(MD_LAT)
  ) u_md_busy (
    .clk  (clk),
    .reset(reset),
    .start(hz.MdStartE),
    .busy (md_busy)
  );

  always_comb begin
    hz.ForwardAE = fwd_e(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    hz.ForwardBE = fwd_e(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    branchstall  = 1'b0;
    if (EARLY_BRANCH) begin
      hz.ForwardAD = (hz.RsD != '0) && (hz.RsD == hz.WriteRegM) && hz.RegWriteM;
      hz.ForwardBD = (hz.RtD != '0) && (hz.RtD == hz.WriteRegM) && hz.RegWriteM;
      branchstall  = hz.BranchD &&
          ((hz.RegWriteE && hz.WriteRegE != '0 &&
            (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
           (hz.MemtoRegM && hz.WriteRegM != '0 &&
            (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
    end
    lwstall = hz.MemtoRegE && (hz.RtE != '0) && (hz.RsD == hz.RtE || hz.RtD == hz.RtE);
    mdstall = hz.MdUseD && (md_busy || hz.MdStartE);
    stall   = lwstall | branchstall | mdstall;

    hz.StallF = stall;
    hz.StallD = stall;
    hz.FlushD = !EARLY_BRANCH && hz.PCSrcE;
    hz.FlushE = stall | hz.JumpD | (!EARLY_BRANCH && hz.PCSrcE);
    hz.MdBusy = md_busy;
  end

  // Counters hold at all-ones rather than wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.StallD && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (hz.FlushE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

endmodule
